// File: rtl/ctrl_data_ext_unit.sv
// Decode-and-memory slice: opcode to control word, 2-bit immediate sign extension,
// and a byte-wide data memory with asynchronous read and clocked write.
module ctrl_data_ext_unit #(
    parameter int ADDR_BITS = 5,
    parameter int DATA_W    = 8
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic [1:0]        opcode,
    output logic [DATA_W-1:0] control,
    input  logic [1:0]        imm_in,
    output logic [DATA_W-1:0] imm_ext,
    input  logic [DATA_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata
);

    localparam int DEPTH = 2 ** ADDR_BITS;

    logic [DATA_W-1:0]    mem_q [DEPTH];
    logic [ADDR_BITS-1:0] mem_idx_s;
    logic                 mem_we_s;
    logic                 unused_addr_s;

    // Control word decode; unknown opcodes fall to an all-zero (no-op) word.
    always_comb begin
        control = 8'b0000_0000;
        case (opcode)
            2'b00:   control = 8'b1100_0001;
            2'b01:   control = 8'b0110_1011;
            2'b10:   control = 8'b0010_0101;
            2'b11:   control = 8'b0001_0000;
            default: control = 8'b0000_0000;
        endcase
    end

    // Immediate sign extension.
    always_comb begin
        imm_ext = {{(DATA_W-2){imm_in[1]}}, imm_in};
    end

    // Upper address bits alias onto the same locations.
    assign mem_idx_s     = mem_addr[ADDR_BITS-1:0];
    assign unused_addr_s = ^mem_addr[DATA_W-1:ADDR_BITS];
    assign mem_we_s      = control[2];
    assign mem_rdata     = mem_q[mem_idx_s];

    // Memory array: reset preloads each location with its own index.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= DATA_W'(i);
            end
        end else if (mem_we_s) begin
            mem_q[mem_idx_s] <= mem_wdata;
        end else begin
            mem_q[mem_idx_s] <= mem_q[mem_idx_s];
        end
    end

endmodule

// File: tb/tb_ctrl_data_ext_unit.sv
// Directed self-checking bench for ctrl_data_ext_unit.
module tb_ctrl_data_ext_unit;

    logic       CLK;
    logic       Reset;
    logic [1:0] opcode;
    logic [7:0] control;
    logic [1:0] imm_in;
    logic [7:0] imm_ext;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;

    int errors;
    int checks;

    ctrl_data_ext_unit dut (
        .CLK       (CLK),
        .Reset     (Reset),
        .opcode    (opcode),
        .control   (control),
        .imm_in    (imm_in),
        .imm_ext   (imm_ext),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic test_reset();
        logic [7:0] addrs [3];
        addrs[0] = 8'h00; addrs[1] = 8'h07; addrs[2] = 8'h1F;
        @(negedge CLK);
        Reset = 1'b0;
        #2;
        Reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            mem_addr = addrs[k];
            #1;
            checks++;
            if (mem_rdata !== addrs[k]) begin
                errors++;
                $display("FAIL reset_read addr=%h got=%h exp=%h", addrs[k], mem_rdata, addrs[k]);
            end
        end
    endtask

    task automatic test_decode();
        logic [7:0] exp_ctrl [4];
        exp_ctrl[0] = 8'hC1; exp_ctrl[1] = 8'h6B; exp_ctrl[2] = 8'h25; exp_ctrl[3] = 8'h10;
        mem_addr = 8'h10;
        for (int k = 0; k < 4; k++) begin
            opcode = 2'(k);
            #1;
            checks++;
            if (control !== exp_ctrl[k]) begin
                errors++;
                $display("FAIL decode op=%0d got=%h exp=%h", k, control, exp_ctrl[k]);
            end
        end
        opcode = 2'b00;
    endtask

    task automatic test_imm();
        logic [7:0] exp_imm [4];
        exp_imm[0] = 8'h00; exp_imm[1] = 8'h01; exp_imm[2] = 8'hFE; exp_imm[3] = 8'hFF;
        for (int k = 0; k < 4; k++) begin
            imm_in = 2'(k);
            #1;
            checks++;
            if (imm_ext !== exp_imm[k]) begin
                errors++;
                $display("FAIL imm_ext imm=%0d got=%h exp=%h", k, imm_ext, exp_imm[k]);
            end
        end
    endtask

    task automatic test_store();
        @(negedge CLK);
        opcode    = 2'b10;
        mem_addr  = 8'h03;
        mem_wdata = 8'hA5;
        #1;
        checks++;
        if (mem_rdata !== 8'h03) begin
            errors++;
            $display("FAIL store_before_edge got=%h exp=%h", mem_rdata, 8'h03);
        end
        @(posedge CLK);
        #1;
        opcode = 2'b00;
        checks++;
        if (mem_rdata !== 8'hA5) begin
            errors++;
            $display("FAIL store_after_edge got=%h exp=%h", mem_rdata, 8'hA5);
        end
        mem_addr = 8'h23;
        #1;
        checks++;
        if (mem_rdata !== 8'hA5) begin
            errors++;
            $display("FAIL store_wrap got=%h exp=%h", mem_rdata, 8'hA5);
        end
    endtask

    task automatic test_non_store();
        logic [1:0] ops [3];
        ops[0] = 2'b00; ops[1] = 2'b01; ops[2] = 2'b11;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            opcode    = ops[k];
            mem_addr  = 8'h04;
            mem_wdata = 8'hFF;
            @(posedge CLK);
            #1;
            checks++;
            if (mem_rdata !== 8'h04) begin
                errors++;
                $display("FAIL non_store op=%0d got=%h exp=%h", ops[k], mem_rdata, 8'h04);
            end
        end
    endtask

    task automatic test_reset_override();
        @(negedge CLK);
        opcode    = 2'b10;
        mem_addr  = 8'h02;
        mem_wdata = 8'h5A;
        @(posedge CLK);
        #1;
        checks++;
        if (mem_rdata !== 8'h5A) begin
            errors++;
            $display("FAIL ovr_write got=%h exp=%h", mem_rdata, 8'h5A);
        end
        @(negedge CLK);
        mem_wdata = 8'h77;
        #1;
        Reset = 1'b0;
        #1;
        checks++;
        if (mem_rdata !== 8'h02) begin
            errors++;
            $display("FAIL ovr_async_reset got=%h exp=%h", mem_rdata, 8'h02);
        end
        repeat (2) @(posedge CLK);
        #1;
        checks++;
        if (mem_rdata !== 8'h02) begin
            errors++;
            $display("FAIL ovr_held_no_write got=%h exp=%h", mem_rdata, 8'h02);
        end
        mem_addr = 8'h03;
        #1;
        checks++;
        if (mem_rdata !== 8'h03) begin
            errors++;
            $display("FAIL ovr_other_restored got=%h exp=%h", mem_rdata, 8'h03);
        end
        @(negedge CLK);
        opcode = 2'b00;
        Reset  = 1'b1;
        mem_addr = 8'h02;
        @(posedge CLK);
        #1;
        checks++;
        if (mem_rdata !== 8'h02) begin
            errors++;
            $display("FAIL ovr_retained got=%h exp=%h", mem_rdata, 8'h02);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge CLK);
        opcode    = 2'b10;
        mem_addr  = 8'h1E;
        mem_wdata = 8'h3C;
        @(negedge CLK);
        mem_addr  = 8'h1F;
        mem_wdata = 8'hC3;
        @(negedge CLK);
        opcode   = 2'b00;
        mem_addr = 8'h1E;
        #1;
        checks++;
        if (mem_rdata !== 8'h3C) begin
            errors++;
            $display("FAIL b2b_first got=%h exp=%h", mem_rdata, 8'h3C);
        end
        mem_addr = 8'h3F;
        #1;
        checks++;
        if (mem_rdata !== 8'hC3) begin
            errors++;
            $display("FAIL b2b_second got=%h exp=%h", mem_rdata, 8'hC3);
        end
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        Reset     = 1'b1;
        opcode    = 2'b00;
        imm_in    = 2'b00;
        mem_addr  = 8'h00;
        mem_wdata = 8'h00;
        test_reset();
        test_decode();
        test_imm();
        test_store();
        test_non_store();
        test_reset_override();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ctrl_data_ext_unit.md
Name: ctrl_data_ext_unit

Overview:
Combined decode-and-memory slice of the 8-bit single-cycle microprocessor. It decodes the 2-bit opcode into the 8-bit control word and sign-extends the 2-bit immediate to 8 bits. It also holds the byte-wide data memory with combinational read and clocked write. It sits between the instruction fetch (instruction[7:6], instruction[1:0]) and the register file / ALU / PC muxes.

Parameters:
ADDR_BITS, 5, number of low address bits used to index data memory; depth is 2**ADDR_BITS bytes.
DATA_W, 8, data/word width. Fixed at 8; other values are not supported.

Ports:
CLK  input  1  system clock; memory writes occur on its rising edge.
Reset  input  1  asynchronous, active-low reset of data memory contents.
opcode  input  2  instruction[7:6].
control  output  8  {RegDst, RegWrite, ALUSrc, Branch, MemRead, MemWrite, MemtoReg, ALUOp}, bit 7 down to bit 0.
imm_in  input  2  instruction[1:0].
imm_ext  output  8  sign-extended immediate.
mem_addr  input  8  data address (ALU result).
mem_wdata  input  8  store data (register read value 2).
mem_rdata  output  8  data read at mem_addr.

Behaviour:
- control is purely combinational from opcode:
  - 00 add: 8'b1100_0001 (RegDst, RegWrite, ALUOp).
  - 01 lw: 8'b0110_1011 (RegWrite, ALUSrc, MemRead, MemtoReg, ALUOp).
  - 10 sw: 8'b0010_0101 (ALUSrc, MemWrite, ALUOp).
  - 11 j: 8'b0001_0000 (Branch only).
  - Any X/Z on opcode: control = 8'b0000_0000.
- imm_ext is combinational: {{6{imm_in[1]}}, imm_in}.
  - 00→0x00, 01→0x01, 10→0xFE, 11→0xFF.
- Memory: 2**ADDR_BITS bytes, indexed by mem_addr[ADDR_BITS-1:0]. Upper address bits are ignored, so addresses alias/wrap (e.g. 0x25 ≡ 0x05 with default parameters).
- Read is asynchronous: mem_rdata = mem[index] at all times, regardless of MemRead. It changes within the same cycle as mem_addr.
- Write: on posedge CLK, if the decoded MemWrite bit (control[2], i.e. opcode==10) is 1, then mem[index] <= mem_wdata. No other opcode writes.
- Write-then-read of the same address: mem_rdata shows the old value until the clock edge and the new value after it. There is no bypass.
- Reset low (asynchronous): every location i is set to i[7:0] (mem[0]=0x00, mem[1]=0x01, …, mem[31]=0x1F).
  - Reset overrides a simultaneous write.
  - While Reset is held low, writes are ignored.
  - Contents are retained after Reset is released.
- Reset does not affect control or imm_ext, which are combinational.
- No internal state other than the memory array. No handshake; single-cycle latency for writes, zero latency for reads and decode.

Test Plan:
- Sweep opcode 00/01/10/11 → control = 0xC1, 0x6B, 0x25, 0x10 respectively.
- Sweep imm_in 00/01/10/11 → imm_ext = 0x00, 0x01, 0xFE, 0xFF.
- Pulse Reset low, then read addresses 0x00, 0x07, 0x1F → mem_rdata = 0x00, 0x07, 0x1F.
- Store: opcode=10, mem_addr=0x03, mem_wdata=0xA5.
  - Before the edge, mem_rdata = 0x03.
  - After posedge CLK, mem_rdata = 0xA5.
  - Address 0x23 also reads 0xA5 (wrap).
- Non-store: opcode=00/01/11 with mem_addr=0x04, mem_wdata=0xFF over several edges → mem_rdata stays 0x04.
- Write 0x5A to 0x02, then assert Reset asynchronously mid-cycle with opcode=10 still applied:
  - mem_rdata at 0x02 returns 0x02 immediately, without waiting for a clock edge.
  - While Reset is held low, edges do not write.
